// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a hard-wired zero register,
// write-through bypass on both read ports, and a sequential clear
// (INIT) that runs after reset and on a flush request.
//
// Handshake/timing: there is no valid/ready handshake. A write is
// accepted on any rising edge where state is READY, we=1, flush_req=0
// and wr_addr != 0. Reads are combinational. init_busy reflects the FSM
// state directly and is the state observation point for checkers.
module regfile_mp #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [AW-1:0]          rs1_addr,
    input  logic [AW-1:0]          rs2_addr,
    input  logic [AW-1:0]          dbg_addr,
    output logic signed [XLEN-1:0] rs1_data,
    output logic signed [XLEN-1:0] rs2_data,
    output logic signed [XLEN-1:0] dbg_data,
    input  logic                   we,
    input  logic [AW-1:0]          wr_addr,
    input  logic signed [XLEN-1:0] wr_data,
    input  logic                   flush_req,
    output logic                   init_busy,
    output logic                   x0_wr_err
);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            x0_err_q, x0_err_d;

    // Register 0 is not stored; only entries 1..NREG-1 exist.
    logic [XLEN-1:0] mem_q [NREG-1:1];

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;

    logic            wr_ok;
    logic [XLEN-1:0] rd1_arr, rd2_arr, rdd_arr;

    // A user write only counts in READY with no flush and a non-zero target.
    assign wr_ok = (state_q == READY) && we && !flush_req && (wr_addr != '0);

    // Next-state logic: clear sequencing, flush entry, array write selection.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        x0_err_d  = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(NREG - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (flush_req) begin
                    state_d   = INIT;
                    clr_cnt_d = AW'(1);
                end else if (we) begin
                    if (wr_addr == '0) begin
                        x0_err_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = INIT;
                clr_cnt_d = AW'(1);
            end
        endcase
    end

    // State, clear counter and error pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= INIT;
            clr_cnt_q <= AW'(1);
            x0_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            x0_err_q  <= x0_err_d;
        end
    end

    // Array write port; reset suppresses any write in that cycle.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we && (mem_waddr != '0)) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Raw array reads with address 0 forced to zero.
    always_comb begin
        rd1_arr = '0;
        rd2_arr = '0;
        rdd_arr = '0;
        if (rs1_addr != '0) rd1_arr = mem_q[rs1_addr];
        if (rs2_addr != '0) rd2_arr = mem_q[rs2_addr];
        if (dbg_addr != '0) rdd_arr = mem_q[dbg_addr];
    end

    // Output muxing: zero during INIT, bypass on the two read ports only.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        dbg_data = '0;
        if (state_q == READY) begin
            rs1_data = (wr_ok && (wr_addr == rs1_addr)) ? wr_data : rd1_arr;
            rs2_data = (wr_ok && (wr_addr == rs2_addr)) ? wr_data : rd2_arr;
            dbg_data = rdd_arr;
        end
    end

    assign init_busy = (state_q == INIT);
    assign x0_wr_err = x0_err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp (XLEN=64, NREG=32).
module tb_regfile_mp;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    // ---------------- clock / reset / DUT ----------------
    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [AW-1:0]          rs1_addr, rs2_addr, dbg_addr, wr_addr;
    logic signed [XLEN-1:0] rs1_data, rs2_data, dbg_data, wr_data;
    logic                   we, flush_req, init_busy, x0_wr_err;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .dbg_addr  (dbg_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .dbg_data  (dbg_data),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .flush_req (flush_req),
        .init_busy (init_busy),
        .x0_wr_err (x0_wr_err)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] wa,
                         input logic [XLEN-1:0] wd, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] ad,
                         input logic fl);
        we = w; wr_addr = wa; wr_data = wd;
        rs1_addr = a1; rs2_addr = a2; dbg_addr = ad; flush_req = fl;
    endtask

    // Counts consecutive negedge samples with init_busy high; stops at the
    // first low sample (left sitting on that negedge). dbg_data and
    // rs1_data must read zero throughout. Bounded.
    task automatic count_busy(output int n, output int nonzero);
        n = 0;
        nonzero = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!init_busy) break;
            n++;
            if (dbg_data !== '0 || rs1_data !== '0 || rs2_data !== '0) nonzero++;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic            w;
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] wd;
        logic [AW-1:0]   a1, a2, ad;
        logic [XLEN-1:0] e1, e2, ed;
        logic            eerr;
    } vec_t;

    localparam logic [XLEN-1:0] DB  = 64'h0000_0000_DEAD_BEEF;
    localparam logic [XLEN-1:0] MSB = 64'h8000_0000_0000_0000;
    localparam logic [XLEN-1:0] AA  = 64'hAA;
    localparam logic [XLEN-1:0] ONES = '1;

    vec_t vecs[10];

    int n_busy, n_nz;

    initial begin
        //            w   wa  wd            a1  a2  ad  e1    e2    ed   eerr
        vecs[0] = '{1'b1, 7,  DB,            7,  0,  7,  DB,   0,    0,   1'b0};
        vecs[1] = '{1'b0, 0,  0,             7,  7,  7,  DB,   DB,   DB,  1'b0};
        vecs[2] = '{1'b1, 0,  ONES,          0,  7,  0,  0,    DB,   0,   1'b0};
        vecs[3] = '{1'b0, 0,  0,             0,  0,  0,  0,    0,    0,   1'b1};
        vecs[4] = '{1'b0, 0,  0,             0,  0,  0,  0,    0,    0,   1'b0};
        vecs[5] = '{1'b1, 31, MSB,           31, 31, 31, MSB,  MSB,  0,   1'b0};
        vecs[6] = '{1'b0, 0,  0,             31, 5,  31, MSB,  AA,   MSB, 1'b0};
        vecs[7] = '{1'b1, 5,  64'h1234,      7,  5,  5,  DB,   64'h1234, AA, 1'b0};
        vecs[8] = '{1'b1, 7,  0,             5,  7,  7,  64'h1234, 0, DB,  1'b0};
        vecs[9] = '{1'b0, 0,  0,             7,  31, 7,  0,    MSB,  0,   1'b0};

        // --- reset with a write held on the bus the whole time ---
        rst_n = 1'b0;
        drive(1'b1, 5, AA, 5, 5, 5, 1'b0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset_busy", {63'd0, init_busy}, 64'd1);
        check("reset_x0err", {63'd0, x0_wr_err}, 64'd0);
        check("reset_dbg", dbg_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // --- init lasts exactly NREG-1 cycles, write ignored ---
        count_busy(n_busy, n_nz);
        check("init_len", n_busy, NREG - 1);
        check("init_reads_zero", n_nz, 0);
        // first READY cycle: array still zero, bypass active on rs1
        check("ready_dbg5_before", dbg_data, 0);
        check("ready_rs1_bypass", rs1_data, AA);
        check("ready_x0err", {63'd0, x0_wr_err}, 64'd0);
        next_cycle();
        @(negedge clk);
        check("ready_dbg5_after", dbg_data, AA);
        @(posedge clk);
        #1;
        drive(1'b0, 0, 0, 0, 0, 0, 1'b0);
        next_cycle();

        // --- table-driven READY vectors ---
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].w, vecs[i].wa, vecs[i].wd, vecs[i].a1, vecs[i].a2,
                  vecs[i].ad, 1'b0);
            @(negedge clk);
            check($sformatf("v%0d_rs1", i), rs1_data, vecs[i].e1);
            check($sformatf("v%0d_rs2", i), rs2_data, vecs[i].e2);
            check($sformatf("v%0d_dbg", i), dbg_data, vecs[i].ed);
            check($sformatf("v%0d_x0err", i), {63'd0, x0_wr_err}, {63'd0, vecs[i].eerr});
            @(posedge clk);
            #1;
        end

        // --- flush with a concurrent write that must be dropped ---
        drive(1'b1, 3, 64'h12, 0, 0, 0, 1'b0);
        next_cycle();
        drive(1'b1, 4, 64'h34, 3, 4, 3, 1'b1);
        @(negedge clk);
        check("flush_rs1_reg3", rs1_data, 64'h12);
        check("flush_rs2_nobypass", rs2_data, 0);
        @(posedge clk);
        #1;
        // keep flush asserted during INIT: must not restart the sequence
        drive(1'b0, 0, 0, 3, 4, 4, 1'b1);
        count_busy(n_busy, n_nz);
        flush_req = 1'b0;
        check("flush_init_len", n_busy, NREG - 1);
        check("flush_init_zero", n_nz, 0);
        check("flush_reg3", rs1_data, 0);
        check("flush_reg4", rs2_data, 0);
        check("flush_dbg4", dbg_data, 0);
        @(posedge clk);
        #1;

        // --- reset at INIT cycle 10 restarts the full sequence ---
        drive(1'b0, 0, 0, 0, 0, 0, 1'b1);
        next_cycle();
        flush_req = 1'b0;
        for (int i = 0; i < 10; i++) next_cycle();
        rst_n = 1'b0;
        drive(1'b1, 9, 64'h99, 9, 0, 9, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        count_busy(n_busy, n_nz);
        check("rst_mid_init_len", n_busy, NREG - 1);
        check("rst_mid_dbg9", dbg_data, 0);
        check("rst_mid_rs1_bypass", rs1_data, 64'h99);

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count; power of two, >= 2.
REQ-003 SHALL derive AW = clog2(NREG) as the address width; it is not overridable.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port rs1_addr, input, AW, read port 1 address.
REQ-007 SHALL have port rs2_addr, input, AW, read port 2 address.
REQ-008 SHALL have port dbg_addr, input, AW, debug/trace read address.
REQ-009 SHALL have port rs1_data, output, XLEN signed, read port 1 data.
REQ-010 SHALL have port rs2_data, output, XLEN signed, read port 2 data.
REQ-011 SHALL have port dbg_data, output, XLEN signed, debug read data (array contents only, no bypass).
REQ-012 SHALL have port we, input, 1, write enable.
REQ-013 SHALL have port wr_addr, input, AW, write address.
REQ-014 SHALL have port wr_data, input, XLEN signed, write data.
REQ-015 SHALL have port flush_req, input, 1, request re-zeroing of the whole file.
REQ-016 SHALL have port init_busy, output, 1, high while the clear sequence runs.
REQ-017 SHALL have port x0_wr_err, output, 1, registered one-cycle pulse on an attempted write to register 0.

Function
REQ-018 SHALL contain the FSM states INIT and READY.
REQ-019 SHALL contain the clear counter clr_cnt, AW bits wide.
REQ-020 SHALL keep register 0 hard-wired to zero; it SHALL NOT be stored, and every read of address 0 SHALL return 0.
REQ-021 In INIT, each cycle SHALL write 0 to reg[clr_cnt] and increment clr_cnt.
REQ-022 In INIT, the cycle that clears reg[NREG-1] SHALL transition the FSM to READY.
REQ-023 INIT SHALL therefore last exactly NREG-1 cycles.
REQ-024 init_busy SHALL equal (state == INIT), taken combinationally from the state register.
REQ-025 In INIT, we SHALL be ignored.
REQ-026 In INIT, rs1_data, rs2_data and dbg_data SHALL read 0.
REQ-027 In READY, flush_req=1 SHALL set state to INIT and clr_cnt to 1 on the next edge; we in that same cycle SHALL be dropped.
REQ-028 In READY, flush_req=1 during INIT SHALL be ignored; the sequence is not restarted.
REQ-029 In READY, we=1 with wr_addr != 0 and flush_req=0 SHALL write reg[wr_addr] = wr_data at the rising edge; the value is visible in the array (dbg_data) from the next cycle.
REQ-030 In READY, we=1 with wr_addr == 0 SHALL leave the array unchanged and set x0_wr_err=1 for exactly the following cycle; otherwise x0_wr_err SHALL be 0.
REQ-031 Reads SHALL be combinational from the address inputs.
REQ-032 Write-through bypass: in READY, when we=1, flush_req=0, wr_addr != 0 and wr_addr == rsN_addr, rsN_data SHALL equal wr_data in the same cycle.
REQ-033 Both read ports SHALL bypass independently; rs1_addr == rs2_addr == wr_addr SHALL drive wr_data on both ports.
REQ-034 All data SHALL be XLEN bits with no truncation or extension; the signed type is for display only.

Reset
REQ-035 rst_n=0 at a rising edge SHALL set state=INIT, clr_cnt=1 and x0_wr_err=0.
REQ-036 rst_n=0 SHALL NOT perform a clear-write to the array that cycle.
REQ-037 The clear sequence SHALL start on the first edge with rst_n=1.
REQ-038 Reset asserted mid-INIT or mid-write SHALL restart the sequence from clr_cnt=1; any write in that cycle SHALL be dropped.
REQ-039 There SHALL be no file preload; contents are defined only after INIT completes.

Verification (XLEN=64, NREG=32)
REQ-040 Bench SHALL cover: release rst_n and hold we=1 wr_addr=5 wr_data=0xAA throughout -> init_busy high exactly 31 cycles, then dbg_addr=5 reads 0 until the first READY write, and 0xAA after it.
REQ-041 Bench SHALL cover: in READY, write reg 7 = 0xDEAD_BEEF with rs1_addr=7 -> rs1_data = 0xDEADBEEF in the same cycle (bypass) and dbg_data(7) = 0xDEADBEEF on the next cycle.
REQ-042 Bench SHALL cover: we=1 wr_addr=0 wr_data=-1 -> rs1_data(0) stays 0 and x0_wr_err pulses high for exactly 1 cycle.
REQ-043 Bench SHALL cover: rs1_addr=rs2_addr=wr_addr=31, we=1, wr_data=0x8000_0000_0000_0000 -> both ports show that value in the same cycle.
REQ-044 Bench SHALL cover: write reg 3 = 0x12, then flush_req=1 together with we=1 wr_addr=4 wr_data=0x34 -> init_busy high 31 cycles, then regs 3 and 4 read 0.
REQ-045 Bench SHALL cover: assert rst_n=0 for 1 cycle at INIT cycle 10 -> init_busy stays high a further 31 cycles from release.
